// File: rtl/logic_pkg.sv
// Shared opcode definitions for the bitwise logic pipeline.
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Request/response bundle for logic_unit_pipe: request handshake, result handshake and op counter.
interface logic_unit_pipe_if
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic [15:0]      op_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out_data, out_zero, op_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out_data, out_zero, op_count
    );

endinterface

// File: rtl/bitwise_op.sv
// Combinational bitwise operation over WIDTH bits with an all-zeros flag on the result.
module bitwise_op
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

    assign zero = ~|y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a DEPTH-entry result FIFO; in_ready depends only on registered count.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    logic_unit_pipe_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] res_y;
    logic             res_zero;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic             zero_q [DEPTH];

    logic push;
    logic pop;
    logic not_empty;
    logic not_full;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    bitwise_op #(
        .WIDTH (WIDTH)
    ) u_bitwise_op (
        .op   (bus.op),
        .a    (bus.a),
        .b    (bus.b),
        .y    (res_y),
        .zero (res_zero)
    );

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q < CNT_W'(DEPTH));

    assign push = bus.in_valid & not_full;
    assign pop  = not_empty & bus.out_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        op_count_d = op_count_q;
        if (push) begin
            wr_ptr_d   = next_ptr(wr_ptr_q);
            op_count_d = op_count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_count_q <= op_count_d;
        end
    end

    // Storage is data-only; emptiness is tracked by count_q, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= res_y;
            zero_q[wr_ptr_q] <= res_zero;
        end
    end

    assign bus.in_ready  = not_full;
    assign bus.out_valid = not_empty;
    assign bus.out_data  = not_empty ? data_q[rd_ptr_q] : '0;
    assign bus.out_zero  = not_empty ? zero_q[rd_ptr_q] : 1'b1;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a 16-bit DEPTH=2 instance plus a 5-bit instance for counter wrap.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic_unit_pipe_if #(.WIDTH(16)) bus16 ();
    logic_unit_pipe_if #(.WIDTH(5))  bus5 ();

    logic_unit_pipe #(.WIDTH(16), .DEPTH(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    logic_unit_pipe #(.WIDTH(5), .DEPTH(2)) u_w5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic v, input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv);
        bus16.in_valid = v;
        bus16.op       = o;
        bus16.a        = av;
        bus16.b        = bv;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        bus16.out_ready = 1'b0;
        bus5.in_valid = 1'b0; bus5.op = 3'd0; bus5.a = '0; bus5.b = '0; bus5.out_ready = 1'b0;
        step();
        checks++;
        if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus16.out_valid); end
        checks++;
        if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus16.in_ready); end
        checks++;
        if (bus16.op_count !== 16'h0) begin failures++; $display("FAIL reset_op_count got=%h exp=0000", bus16.op_count); end
        checks++;
        if (bus16.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", bus16.out_data); end
        // Request offered while reset is high must not be taken.
        drive16(1'b1, OP_PASS, 16'hABCD, 16'h0);
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        reset = 1'b0;
        step();
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.op_count !== 16'h0) begin
            failures++; $display("FAIL reset_no_accept valid=%b count=%h exp valid=0 count=0000", bus16.out_valid, bus16.op_count);
        end
    endtask

    task automatic test_not();
        bus16.out_ready = 1'b0;
        drive16(1'b1, OP_NOT, 16'h0110, 16'h0);
        checks++;
        if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL not_pre_valid got=%b exp=0", bus16.out_valid); end
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (bus16.out_valid !== 1'b1) begin failures++; $display("FAIL not_latency got=%b exp=1", bus16.out_valid); end
        checks++;
        if (bus16.out_data !== 16'hFEEF || bus16.out_zero !== 1'b0) begin
            failures++; $display("FAIL not_result got=%h/%b exp=FEEF/0", bus16.out_data, bus16.out_zero);
        end
        checks++;
        if (bus16.op_count !== 16'd1) begin failures++; $display("FAIL not_op_count got=%0d exp=1", bus16.op_count); end
        bus16.out_ready = 1'b1;
        step();
        checks++;
        if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL not_pop got=%b exp=0", bus16.out_valid); end
    endtask

    task automatic test_and_xor();
        bus16.out_ready = 1'b0;
        drive16(1'b1, OP_AND, 16'h1A27, 16'h9C48);
        step();
        drive16(1'b1, OP_XOR, 16'h1A27, 16'h9C48);
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (bus16.in_ready !== 1'b0) begin failures++; $display("FAIL andxor_full got=%b exp=0", bus16.in_ready); end
        checks++;
        if (bus16.out_data !== 16'h1800) begin failures++; $display("FAIL andxor_first got=%h exp=1800", bus16.out_data); end
        bus16.out_ready = 1'b1;
        step();
        checks++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== 16'h866F) begin
            failures++; $display("FAIL andxor_second got=%b/%h exp=1/866F", bus16.out_valid, bus16.out_data);
        end
        step();
        checks++;
        if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL andxor_drain got=%b exp=0", bus16.out_valid); end
    endtask

    task automatic test_zero();
        bus16.out_ready = 1'b1;
        drive16(1'b1, OP_AND, 16'h0047, 16'h0110);
        step();
        checks++;
        if (bus16.out_data !== 16'h0000 || bus16.out_zero !== 1'b1) begin
            failures++; $display("FAIL zero_and got=%h/%b exp=0000/1", bus16.out_data, bus16.out_zero);
        end
        drive16(1'b1, OP_NOT, 16'h0000, 16'h0);
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (bus16.out_data !== 16'hFFFF || bus16.out_zero !== 1'b0) begin
            failures++; $display("FAIL zero_not got=%h/%b exp=FFFF/0", bus16.out_data, bus16.out_zero);
        end
        step();
    endtask

    task automatic test_other_ops();
        bus16.out_ready = 1'b1;
        drive16(1'b1, OP_XNOR, 16'hF0F0, 16'hFF00);
        step();
        checks++;
        if (bus16.out_data !== 16'hF00F) begin failures++; $display("FAIL op_xnor got=%h exp=F00F", bus16.out_data); end
        drive16(1'b1, OP_PASS, 16'h1234, 16'hFFFF);
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (bus16.out_data !== 16'h1234) begin failures++; $display("FAIL op_pass got=%h exp=1234", bus16.out_data); end
        step();
    endtask

    task automatic test_backpressure();
        pulse_reset();
        bus16.out_ready = 1'b0;
        drive16(1'b1, OP_OR, 16'h00F0, 16'h0F00);
        step();
        checks++;
        if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 got=%b exp=1", bus16.in_ready); end
        drive16(1'b1, OP_NAND, 16'hFFFF, 16'h00FF);
        step();
        checks++;
        if (bus16.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after2 got=%b exp=0", bus16.in_ready); end
        drive16(1'b1, OP_NOR, 16'h0000, 16'h0001);
        step();
        checks++;
        if (bus16.out_data !== 16'h0FF0 || bus16.out_zero !== 1'b0 || bus16.op_count !== 16'd2) begin
            failures++; $display("FAIL bp_hold got=%h/%b cnt=%0d exp=0FF0/0 cnt=2", bus16.out_data, bus16.out_zero, bus16.op_count);
        end
        // Pop while full: the pending request must still be refused on this edge.
        bus16.out_ready = 1'b1;
        step();
        checks++;
        if (bus16.out_data !== 16'hFF00 || bus16.op_count !== 16'd2 || bus16.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_full_pop got=%h cnt=%0d rdy=%b exp=FF00 cnt=2 rdy=1", bus16.out_data, bus16.op_count, bus16.in_ready);
        end
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== 16'hFFFE) begin
            failures++; $display("FAIL bp_third got=%b/%h exp=1/FFFE", bus16.out_valid, bus16.out_data);
        end
        checks++;
        if (bus16.op_count !== 16'd3) begin failures++; $display("FAIL bp_op_count got=%0d exp=3", bus16.op_count); end
        step();
        checks++;
        if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus16.out_valid); end
    endtask

    task automatic test_async_reset();
        bus16.out_ready = 1'b0;
        drive16(1'b1, OP_PASS, 16'h1111, 16'h0);
        step();
        drive16(1'b1, OP_PASS, 16'h2222, 16'h0);
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) begin
            failures++; $display("FAIL ar_prefill rdy=%b vld=%b exp rdy=0 vld=1", bus16.in_ready, bus16.out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.op_count !== 16'h0) begin
            failures++; $display("FAIL ar_immediate vld=%b rdy=%b cnt=%h exp vld=0 rdy=1 cnt=0000", bus16.out_valid, bus16.in_ready, bus16.op_count);
        end
        reset = 1'b0;
        bus16.out_ready = 1'b1;
        step();
        checks++;
        if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL ar_no_stale got=%b exp=0", bus16.out_valid); end
        drive16(1'b1, OP_PASS, 16'h3333, 16'h0);
        step();
        drive16(1'b0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== 16'h3333) begin
            failures++; $display("FAIL ar_new_req got=%b/%h exp=1/3333", bus16.out_valid, bus16.out_data);
        end
        step();
    endtask

    task automatic test_wrap();
        pulse_reset();
        bus5.out_ready = 1'b1;
        bus5.in_valid  = 1'b1;
        bus5.op        = OP_NOT;
        bus5.a         = 5'b10110;
        bus5.b         = 5'b00000;
        for (int i = 0; i < 65536; i++) step();
        checks++;
        if (bus5.op_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", bus5.op_count); end
        step();
        bus5.in_valid = 1'b0;
        checks++;
        if (bus5.op_count !== 16'h0001) begin failures++; $display("FAIL wrap_one got=%h exp=0001", bus5.op_count); end
        checks++;
        if (bus5.out_valid !== 1'b1 || bus5.out_data !== 5'b01001 || bus5.out_zero !== 1'b0) begin
            failures++; $display("FAIL wrap_not5 got=%b/%b/%b exp=1/01001/0", bus5.out_valid, bus5.out_data, bus5.out_zero);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_not();
        test_and_xor();
        test_zero();
        test_other_ops();
        test_backpressure();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
